uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver, the successor to the fixed 8N1 receiver in the peripheral subsystem.
- Oversampled by an external baud tick; configurable data width, parity and stop bits.
- Majority-vote bit sampling, false-start rejection, framing/parity/break/overrun detection.
- Valid/ready output handshake toward the APB UART register block or RX FIFO.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 0 = even parity, 1 = odd (ignored when PARITY_EN=0)
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, ticks per bit; even, >= 8

Ports:
clk  in  1  system clock
rst  in  1  reset
rx  in  1  asynchronous serial line, idle high
tick  in  1  one-clk pulse, OVERSAMPLE per bit period
rx_ready  in  1  consumer accepts rx_data when high with rx_valid
rx_data  out  DATA_BITS  received word, held while rx_valid
rx_valid  out  1  word available; held until accepted
rx_busy  out  1  frame reception in progress
parity_err  out  1  parity mismatch, qualified by rx_valid
frame_err  out  1  stop bit sampled low, qualified by rx_valid
break_det  out  1  all-zero frame including stop, qualified by rx_valid
overrun_err  out  1  one-clk pulse, completed frame dropped

Behaviour:
- Reset rst asynchronous, active-high; clock clk. All outputs 0 on reset, FSM to IDLE, counters 0, synchroniser flops to 1.
- rx passes through a 2-flop synchroniser (rx_s); rx to rx_s latency 2 clk.
- Per-bit tick counter cnt runs 0..OVERSAMPLE-1 and advances only on tick. Samples are taken at cnt = M-1, M, M+1 with M = OVERSAMPLE/2. Bit value = majority of 3, evaluated on the tick where cnt = M+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rx_s==0 -> START, cnt=0.
- START: bit value 1 -> IDLE (false start, no outputs). At cnt=OVERSAMPLE-1 -> DATA.
- DATA: bit i goes into the shift register, LSB first. After bit DATA_BITS-1 ends -> PARITY if PARITY_EN, else STOP.
- PARITY: computed = XOR(data) XOR PARITY_ODD; mismatch with the sampled bit sets the pending parity_err.
- STOP: each stop bit is sampled. Any stop value 0 sets the pending frame_err. On the majority evaluation of the last stop bit the frame completes: -> IDLE if stop OK, else -> WAIT_HIGH. There is no wait for the end of the stop bit (early resync).
- WAIT_HIGH: stay until rx_s==1, then -> IDLE. This prevents a held-low line from retriggering.
- Break: data all 0, parity bit 0 (if present) and all stop 0 -> break_det=1 and frame_err=1.
- rx_busy is registered: 1 in every state except IDLE. It drops one clk after returning to IDLE.
- Completion: on the clk edge following the completing tick, rx_data and the error flags load and rx_valid=1. Frames with errors are still delivered.
- Handshake: rx_valid & rx_ready at a clk edge clears rx_valid. rx_data and error flags hold their values until reloaded.
- Overrun: completion while rx_valid=1 and not accepted in the same clk -> new frame discarded, old data/flags kept, overrun_err pulses 1 clk.
- Simultaneous accept and completion in the same clk -> new frame loads, rx_valid stays 1, no overrun.
- tick high in a cycle where rx_s falls: the IDLE->START transition takes priority; the counter starts from 0 on the next tick.
- Reset mid-frame: immediate return to IDLE. Any pending rx_valid is lost.

Decomposition:
- Shared package uart_pkg: state enum (uart_rx_state_t), parity-mode localparams, function for majority-of-3.
- One sub-module: uart_bit_sync, a 2-flop synchroniser with reset value 1, reused by the TX loopback path.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 -> rx_valid rises about 9.5 bit times (~152 ticks) after the start edge; rx_data=0xA5; all error flags 0; rx_busy high throughout the frame.
- 8E1, send 0x3C with parity bit 1 (correct value is 0) -> rx_data=0x3C, parity_err=1, frame_err=0.
- Start glitch: rx low for 4 ticks then high -> no rx_valid, FSM back in IDLE; a following 0x55 is received correctly.
- Break: rx held low for 20 bit times -> one frame with rx_data=0x00, break_det=1, frame_err=1; no further frames until rx returns high.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once. Then rx_ready=1 for one clk -> rx_valid=0.
- Config DATA_BITS=7, STOP_BITS=2, PARITY_ODD=1: send 0x7F with second stop bit 0 -> frame_err=1, FSM enters WAIT_HIGH. Separately, assert rst mid-frame -> all outputs 0 and the next frame is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver and its helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

    localparam logic UART_PAR_EVEN = 1'b0;
    localparam logic UART_PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for an idle-high serial line; resets to 1.
module uart_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampled UART receiver: majority-vote sampling, false-start
// rejection, parity/framing/break/overrun detection, valid/ready output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 tick,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_EVAL = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? UART_PAR_ODD : UART_PAR_EVEN;

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter combination");
    end

    logic rx_s;

    uart_bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    uart_rx_state_t       state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic                 s0_q;
    logic                 s1_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 one_seen_q;
    logic                 done_q;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 brk_q;
    logic                 ovr_q;

    logic          bit_d;
    logic          eval_d;
    logic          last_d;
    logic [CW-1:0] cnt_d;

    always_comb begin
        bit_d  = maj3(s0_q, s1_q, rx_s);
        eval_d = tick && (cnt_q == CNT_EVAL);
        last_d = tick && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            one_seen_q <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            busy_q <= (state_q != ST_IDLE);

            if (tick && cnt_q == CNT_S0) s0_q <= rx_s;
            if (tick && cnt_q == CNT_S1) s1_q <= rx_s;

            case (state_q)
                ST_IDLE: begin
                    // Falling edge wins over a coincident tick: count restarts at 0.
                    if (!rx_s) begin
                        state_q    <= ST_START;
                        cnt_q      <= '0;
                        par_err_q  <= 1'b0;
                        frm_err_q  <= 1'b0;
                        one_seen_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        cnt_q <= cnt_d;
                        if (eval_d && bit_d) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else if (last_d) begin
                            state_q   <= ST_DATA;
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        cnt_q <= cnt_d;
                        if (eval_d) shift_q <= {bit_d, shift_q[DATA_BITS-1:1]};
                        if (last_d) begin
                            cnt_q <= '0;
                            if (bit_idx_q == BIT_LAST) begin
                                state_q    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                                stop_idx_q <= 1'b0;
                            end else begin
                                bit_idx_q <= bit_idx_q + BW'(1);
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        cnt_q <= cnt_d;
                        if (eval_d) begin
                            if (bit_d != ((^shift_q) ^ PAR_MODE)) par_err_q <= 1'b1;
                            if (bit_d) one_seen_q <= 1'b1;
                        end
                        if (last_d) begin
                            state_q    <= ST_STOP;
                            cnt_q      <= '0;
                            stop_idx_q <= 1'b0;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        cnt_q <= cnt_d;
                        if (eval_d) begin
                            if (!bit_d) frm_err_q  <= 1'b1;
                            else        one_seen_q <= 1'b1;
                            // Frame completes mid last stop bit so the next start edge is not missed.
                            if (stop_idx_q == STOP_LAST) begin
                                done_q  <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= (frm_err_q || !bit_d) ? ST_WAIT_HIGH : ST_IDLE;
                            end
                        end else if (last_d) begin
                            cnt_q      <= '0;
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase

            if (done_q) begin
                if (valid_q && !rx_ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    data_q  <= shift_q;
                    perr_q  <= par_err_q;
                    ferr_q  <= frm_err_q;
                    brk_q   <= (shift_q == '0) && !one_seen_q;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_busy     = busy_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign break_det   = brk_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomised bench for uart_rx_cfg in 8N1, 8E1 and 7O2 builds.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int OS = 16;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } frm_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic v0, v1, v2, b0, b1, b2;
    logic pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, ov0, ov1, ov2;

    int nerr = 0;
    int nchk = 0;
    int tdiv = 0;
    int ovc0 = 0;
    int lat;
    logic busy_ok;
    frm_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv = (tdiv == 3) ? 0 : tdiv + 1;
        tick = (tdiv == 0);
    end

    uart_rx_cfg u0 (
        .clk(clk), .rst(rst), .rx(rx0), .tick(tick), .rx_ready(rdy0),
        .rx_data(d0), .rx_valid(v0), .rx_busy(b0), .parity_err(pe0),
        .frame_err(fe0), .break_det(bk0), .overrun_err(ov0)
    );

    uart_rx_cfg #(.PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .rx(rx1), .tick(tick), .rx_ready(rdy1),
        .rx_data(d1), .rx_valid(v1), .rx_busy(b1), .parity_err(pe1),
        .frame_err(fe1), .break_det(bk1), .overrun_err(ov1)
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx(rx2), .tick(tick), .rx_ready(rdy2),
        .rx_data(d2), .rx_valid(v2), .rx_busy(b2), .parity_err(pe2),
        .frame_err(fe2), .break_det(bk2), .overrun_err(ov2)
    );

    // Accepted words are collected per receiver.
    always @(negedge clk) begin
        if (v0 && rdy0) q0.push_back('{d: {1'b0, d0}, pe: pe0, fe: fe0, bk: bk0});
        if (v1 && rdy1) q1.push_back('{d: {1'b0, d1}, pe: pe1, fe: fe1, bk: bk1});
        if (v2 && rdy2) q2.push_back('{d: {2'b00, d2}, pe: pe2, fe: fe2, bk: bk2});
        if (ov0) ovc0++;
    end

    function automatic int cfg_db(input int w);
        return (w == 2) ? 7 : 8;
    endfunction
    function automatic logic cfg_pen(input int w);
        return (w != 0);
    endfunction
    function automatic logic cfg_odd(input int w);
        return (w == 2);
    endfunction
    function automatic int cfg_sb(input int w);
        return (w == 2) ? 2 : 1;
    endfunction

    // Expected word and flags from the bit values placed on the line.
    function automatic frm_t model(input int w, input logic [8:0] d, input logic pb,
                                   input logic [1:0] st);
        frm_t f;
        int ones = 0;
        logic want_pb;
        logic all_stop_low;
        f.d = '0;
        for (int i = 0; i < cfg_db(w); i++) begin
            f.d[i] = d[i];
            if (d[i]) ones++;
        end
        want_pb = ((ones % 2) == 1) ^ cfg_odd(w);
        f.pe = cfg_pen(w) && (pb != want_pb);
        all_stop_low = !st[0] && (cfg_sb(w) == 1 || !st[1]);
        f.fe = !st[0] || (cfg_sb(w) == 2 && !st[1]);
        f.bk = (ones == 0) && (!cfg_pen(w) || !pb) && all_stop_low;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic set_rx(input int w, input logic v);
        case (w)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic send_frame(input int w, input logic [8:0] d, input logic pb,
                              input logic [1:0] st, input int idle_bits);
        set_rx(w, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < cfg_db(w); i++) begin
            set_rx(w, d[i]);
            wait_ticks(OS);
        end
        if (cfg_pen(w)) begin
            set_rx(w, pb);
            wait_ticks(OS);
        end
        for (int i = 0; i < cfg_sb(w); i++) begin
            set_rx(w, st[i]);
            wait_ticks(OS);
        end
        set_rx(w, 1'b1);
        wait_ticks(OS * idle_bits);
    endtask

    task automatic expect_frame(input string tag, input int w, input logic [8:0] d,
                                input logic pb, input logic [1:0] st);
        frm_t e, o;
        int n;
        e = model(w, d, pb, st);
        n = (w == 0) ? q0.size() : (w == 1) ? q1.size() : q2.size();
        chk({tag, "_count"}, n, 1);
        if (n > 0) begin
            case (w)
                0: o = q0.pop_front();
                1: o = q1.pop_front();
                default: o = q2.pop_front();
            endcase
            chk({tag, "_data"}, o.d, e.d);
            chk({tag, "_parity_err"}, o.pe, e.pe);
            chk({tag, "_frame_err"}, o.fe, e.fe);
            chk({tag, "_break_det"}, o.bk, e.bk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] rd;
        logic       rpb;
        logic [1:0] rst_bits;
        int         n;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_valid", v0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_data", d0, 0);
        chk("rst_perr", pe0, 0);
        chk("rst_ferr", fe0, 0);
        chk("rst_break", bk0, 0);
        chk("rst_overrun", ov0, 0);
        rst = 1'b0;
        wait_ticks(4);

        // 8N1 0xA5: latency and busy across the frame
        fork
            send_frame(0, 9'h0A5, 1'b0, 2'b11, 2);
            begin
                lat = 0;
                busy_ok = 1'b1;
                while (!v0 && lat < 2000) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (!v0 && lat >= 5 && !b0) busy_ok = 1'b0;
                end
            end
        join
        chk("a5_latency_window", (lat >= 600 && lat <= 632), 1);
        chk("a5_busy_during_frame", busy_ok, 1);
        expect_frame("a5", 0, 9'h0A5, 1'b0, 2'b11);

        // 8E1 0x3C with wrong parity bit
        send_frame(1, 9'h03C, 1'b1, 2'b11, 2);
        expect_frame("3c_even", 1, 9'h03C, 1'b1, 2'b11);

        // False start: low for 4 ticks only
        set_rx(0, 1'b0);
        wait_ticks(4);
        set_rx(0, 1'b1);
        wait_ticks(2 * OS);
        chk("glitch_no_frame", q0.size(), 0);
        chk("glitch_not_busy", b0, 0);
        chk("glitch_idle", u0.state_q, ST_IDLE);
        send_frame(0, 9'h055, 1'b0, 2'b11, 2);
        expect_frame("after_glitch", 0, 9'h055, 1'b0, 2'b11);

        // Break: line low for 20 bit times
        set_rx(0, 1'b0);
        wait_ticks(20 * OS);
        chk("break_one_frame_while_low", q0.size(), 1);
        chk("break_wait_high", u0.state_q, ST_WAIT_HIGH);
        set_rx(0, 1'b1);
        wait_ticks(2 * OS);
        expect_frame("break", 0, 9'h000, 1'b0, 2'b00);

        // Overrun with consumer stalled
        rdy0 = 1'b0;
        n = ovc0;
        send_frame(0, 9'h011, 1'b0, 2'b11, 1);
        send_frame(0, 9'h022, 1'b0, 2'b11, 2);
        chk("ovr_valid_held", v0, 1);
        chk("ovr_data_kept", d0, 8'h11);
        chk("ovr_pulses", ovc0 - n, 1);
        @(posedge clk);
        #1 rdy0 = 1'b1;
        @(posedge clk);
        #1 rdy0 = 1'b0;
        chk("ovr_accept_clears_valid", v0, 0);
        expect_frame("ovr_accepted", 0, 9'h011, 1'b0, 2'b11);
        rdy0 = 1'b1;

        // 7O2: second stop bit low
        fork
            send_frame(2, 9'h07F, 1'b0, 2'b01, 2);
            begin
                n = 0;
                while (!v2 && n < 3000) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("7o2_valid_seen", v2, 1);
                chk("7o2_wait_high", u2.state_q, ST_WAIT_HIGH);
                chk("7o2_busy", b2, 1);
            end
        join
        expect_frame("7o2_stop2_low", 2, 9'h07F, 1'b0, 2'b01);

        // Reset mid-frame with a word pending
        rdy0 = 1'b0;
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1);
        chk("pending_before_reset", v0, 1);
        set_rx(0, 1'b0);
        wait_ticks(OS);
        set_rx(0, 1'b1);
        wait_ticks(OS + OS / 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", v0, 0);
        chk("midrst_busy", b0, 0);
        chk("midrst_data", d0, 0);
        chk("midrst_flags", {pe0, fe0, bk0, ov0}, 0);
        chk("midrst_idle", u0.state_q, ST_IDLE);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rdy0 = 1'b1;
        wait_ticks(2 * OS);
        chk("midrst_word_lost", q0.size(), 0);
        send_frame(0, 9'h096, 1'b0, 2'b11, 2);
        expect_frame("after_rst", 0, 9'h096, 1'b0, 2'b11);

        // Randomised frames on every build
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 6; k++) begin
                rd = 9'($urandom);
                rpb = 1'($urandom_range(1, 0));
                rst_bits = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b11;
                send_frame(w, rd, rpb, rst_bits, 2);
                expect_frame($sformatf("rand_w%0d_%0d", w, k), w, rd, rpb, rst_bits);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
